// File: rtl/md5_bf_sched_if.sv
// Host and worker-bank signals of the md5_bf work scheduler, bundled for port use.
// master = scheduler side, slave = host plus the md5_bf cores.
interface md5_bf_sched_if #(
    parameter int N_WORKERS = 4
);
    logic                    start;
    logic [127:0]            hash;
    logic                    busy;
    logic                    done;
    logic                    found;
    logic [31:0]             pass;
    logic [N_WORKERS-1:0]    w_rst_n;
    logic [N_WORKERS-1:0]    w_start;
    logic [32*N_WORKERS-1:0] w_low;
    logic [32*N_WORKERS-1:0] w_high;
    logic [127:0]            w_hash;
    logic [N_WORKERS-1:0]    w_done;
    logic [N_WORKERS-1:0]    w_found;
    logic [32*N_WORKERS-1:0] w_pass;

    modport master (
        input  start, hash, w_done, w_found, w_pass,
        output busy, done, found, pass, w_rst_n, w_start, w_low, w_high, w_hash
    );
    modport slave (
        output start, hash, w_done, w_found, w_pass,
        input  busy, done, found, pass, w_rst_n, w_start, w_low, w_high, w_hash
    );
endinterface

// File: rtl/md5_bf_sched.sv
// Deals CHUNK-sized slices of [RANGE_LO, RANGE_HI] to idle md5_bf cores, stops the bank on first match.
// Latency: start -> first w_start 3 cycles; w_found -> done 1 cycle.
// Backpressure: none; slices wait for an idle core, start is ignored while a search runs.
module md5_bf_sched #(
    parameter int          N_WORKERS = 4,
    parameter logic [31:0] CHUNK     = 32'h00100000,
    parameter logic [31:0] RANGE_LO  = 32'h00000000,
    parameter logic [31:0] RANGE_HI  = 32'h99999999
) (
    input  logic           clk,
    input  logic           reset_n,
    md5_bf_sched_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_state_t;
    typedef enum logic [1:0] {W_IDLE, W_RST, W_START, W_RUN} wrk_state_t;

    top_state_t              state_q, state_d;
    wrk_state_t              wst_q [N_WORKERS];
    wrk_state_t              wst_d [N_WORKERS];
    logic [31:0]             next_q, next_d;
    logic                    exh_q, exh_d;
    logic [127:0]            hash_q, hash_d;
    logic                    found_q, found_d;
    logic [31:0]             pass_q, pass_d;
    logic [32*N_WORKERS-1:0] low_q, low_d, high_q, high_d;
    logic [32:0]             sum, hi_cand;
    logic [31:0]             slice_hi;
    logic                    all_idle, disp_done;

    always_comb begin
        // 33-bit arithmetic so a slice running past 2^32 clamps instead of wrapping
        sum      = {1'b0, next_q} + {1'b0, CHUNK};
        hi_cand  = sum - 33'd1;
        slice_hi = (sum[32] || (hi_cand > {1'b0, RANGE_HI})) ? RANGE_HI : hi_cand[31:0];

        state_d   = state_q;
        next_d    = next_q;
        exh_d     = exh_q;
        hash_d    = hash_q;
        found_d   = found_q;
        pass_d    = pass_q;
        low_d     = low_q;
        high_d    = high_q;
        disp_done = 1'b0;
        all_idle  = 1'b1;
        for (int i = 0; i < N_WORKERS; i++) begin
            wst_d[i] = wst_q[i];
            if (wst_q[i] != W_IDLE) all_idle = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    hash_d  = bus.hash;
                    next_d  = RANGE_LO;
                    exh_d   = (RANGE_LO > RANGE_HI);
                    found_d = 1'b0;
                    pass_d  = 32'h0;
                end
            end
            S_RUN: begin
                for (int i = 0; i < N_WORKERS; i++) begin
                    case (wst_q[i])
                        W_RST:   wst_d[i] = W_START;
                        W_START: wst_d[i] = W_RUN;
                        W_RUN:   if (bus.w_done[i]) wst_d[i] = W_IDLE;
                        default: begin
                            if (!disp_done && !exh_q) begin
                                wst_d[i]             = W_RST;
                                low_d[32*i +: 32]    = next_q;
                                high_d[32*i +: 32]   = slice_hi;
                                next_d               = sum[31:0];
                                exh_d                = sum[32] || (sum[31:0] > RANGE_HI);
                                disp_done            = 1'b1;
                            end
                        end
                    endcase
                end
                // a match outranks any done or dispatch in the same cycle
                if (|bus.w_found) begin
                    state_d = S_DONE;
                    found_d = 1'b1;
                    for (int i = N_WORKERS - 1; i >= 0; i--) begin
                        if (bus.w_found[i]) pass_d = bus.w_pass[32*i +: 32];
                    end
                    for (int i = 0; i < N_WORKERS; i++) wst_d[i] = W_IDLE;
                end else if (exh_q && all_idle) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            next_q  <= RANGE_LO;
            exh_q   <= 1'b0;
            hash_q  <= '0;
            found_q <= 1'b0;
            pass_q  <= '0;
            low_q   <= '0;
            high_q  <= '0;
            for (int i = 0; i < N_WORKERS; i++) wst_q[i] <= W_IDLE;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            exh_q   <= exh_d;
            hash_q  <= hash_d;
            found_q <= found_d;
            pass_q  <= pass_d;
            low_q   <= low_d;
            high_q  <= high_d;
            for (int i = 0; i < N_WORKERS; i++) wst_q[i] <= wst_d[i];
        end
    end

    always_comb begin
        bus.busy   = (state_q == S_RUN);
        bus.done   = (state_q == S_DONE);
        bus.found  = found_q;
        bus.pass   = pass_q;
        bus.w_hash = hash_q;
        bus.w_low  = low_q;
        bus.w_high = high_q;
        bus.w_rst_n = '0;
        bus.w_start = '0;
        for (int i = 0; i < N_WORKERS; i++) begin
            bus.w_rst_n[i] = (state_q == S_RUN) && ((wst_q[i] == W_START) || (wst_q[i] == W_RUN));
            bus.w_start[i] = (wst_q[i] == W_START);
        end
    end
endmodule
